// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional fetch address range check enabled by defining FETCH_RANGE_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 101
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        range_fault;

`ifdef FETCH_RANGE_CHECK_EN
  assign range_fault = (pc_q[31:10] != '0) || (32'(pc_q[9:2]) >= IMEM_DEPTH);
`else
  assign range_fault = 1'b0;
`endif

  // Redirect targets are forced word-aligned, so the low bits are ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    fetch_fault_d = 1'b0;
    fault_pc_d    = fault_pc_q;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      state_d    = StRun;
    end else begin
      case (state_q)
        StBoot: begin
          state_d = StRun;
          if (id_ready) id_valid_d = 1'b0;
        end
        StRun: begin
          if (range_fault) begin
            // Faulting fetch loads nothing; a held entry survives until accepted.
            fetch_fault_d = 1'b1;
            fault_pc_d    = pc_q;
            state_d       = StHalt;
            if (id_ready) id_valid_d = 1'b0;
          end else if (!id_valid_q || id_ready) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = imem_instr;
            pc_d       = pc_q + 32'd4;
          end
        end
        StHalt: begin
          if (id_ready) id_valid_d = 1'b0;
        end
        default: begin
          state_d    = StBoot;
          id_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'h0;
      id_instr_q    <= 32'h0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      fetch_fault_q <= fetch_fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc_q + 32'd4;
  assign fetch_fault = fetch_fault_q;
  assign fault_pc    = fault_pc_q;
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scoreboard of expected issued PCs plus
// directed checks of boot, stall, redirect, range fault and reset behaviour.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic        halted;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign imem_instr = imem_f(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({id_valid, fetch_fault, halted} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {id_valid, fetch_fault, halted});
    end
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want 00000000", imem_addr);
    end
    n_cmp++;
    if ({id_pc, id_instr, fault_pc} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h %h %h want zeros", id_pc, id_instr, fault_pc);
    end
    n_cmp++;
    if (id_pc_plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_plus4: got %h want 00000004", id_pc_plus4);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL boot_cycle: got v=%b addr=%h want v=0 addr=0", id_valid, imem_addr);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    repeat (3) begin
      step();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++;
      if ({id_valid, id_pc, id_instr, id_pc_plus4} !== {1'b1, e, imem_f(e), e + 32'd4}) begin
        n_fail++;
        $display("FAIL seq_issue: got v=%b pc=%h ins=%h p4=%h want pc=%h", id_valid, id_pc,
                 id_instr, id_pc_plus4, e);
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] e;
    repeat (3) begin
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'd8, imem_f(32'd8), 32'd12}) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b pc=%h ins=%h addr=%h want pc=8 addr=c", id_valid,
                 id_pc, id_instr, imem_addr);
      end
    end
    id_ready = 1'b1;
    exp_q.push_back(32'd12);
    step();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, e, imem_f(e)}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b pc=%h want pc=%h", id_valid, id_pc, e);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    id_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    n_cmp++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%b addr=%h want v=0 addr=40", id_valid, imem_addr);
    end
    exp_q.push_back(32'h40);
    step();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, e, imem_f(e)}) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%b pc=%h want pc=%h", id_valid, id_pc, e);
    end
    // Redirect coinciding with acceptance: held entry dropped, nothing new loaded.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL redirect_accept: got v=%b addr=%h want v=0 addr=100", id_valid, imem_addr);
    end
    exp_q.push_back(32'h100);
    step();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++;
    if ({id_valid, id_pc} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL redirect_accept_next: got v=%b pc=%h want pc=%h", id_valid, id_pc, e);
    end
  endtask

  task automatic test_range();
    logic [31:0] e;
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd396;
    step();
    redirect_valid = 1'b0;
    exp_q.push_back(32'd396);
    exp_q.push_back(32'd400);
    repeat (2) begin
      step();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, e, imem_f(e)}) begin
        n_fail++;
        $display("FAIL range_run: got v=%b pc=%h want pc=%h", id_valid, id_pc, e);
      end
    end
`ifdef FETCH_RANGE_CHECK_EN
    step();
    n_cmp++;
    if ({fetch_fault, halted, id_valid, fault_pc} !== {3'b110, 32'd404}) begin
      n_fail++;
      $display("FAIL fault_pulse: got ff=%b h=%b v=%b fpc=%h want 1 1 0 194", fetch_fault,
               halted, id_valid, fault_pc);
    end
    step();
    n_cmp++;
    if ({fetch_fault, halted, id_valid, imem_addr} !== {3'b010, 32'd404}) begin
      n_fail++;
      $display("FAIL halt_hold: got ff=%b h=%b v=%b addr=%h want 0 1 0 194", fetch_fault,
               halted, id_valid, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({halted, id_valid, imem_addr, fault_pc} !== {2'b00, 32'h0, 32'd404}) begin
      n_fail++;
      $display("FAIL halt_exit: got h=%b v=%b addr=%h fpc=%h want 0 0 0 194", halted, id_valid,
               imem_addr, fault_pc);
    end
    exp_q.push_back(32'h0);
    step();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, e, imem_f(e)}) begin
      n_fail++;
      $display("FAIL resume: got v=%b pc=%h want pc=%h", id_valid, id_pc, e);
    end
`else
    exp_q.push_back(32'd404);
    exp_q.push_back(32'd408);
    repeat (2) begin
      step();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++;
      if ({id_valid, id_pc, id_instr, fetch_fault, halted, fault_pc}
          !== {1'b1, e, imem_f(e), 2'b00, 32'h0}) begin
        n_fail++;
        $display("FAIL no_check_run: got v=%b pc=%h ff=%b h=%b fpc=%h want pc=%h", id_valid,
                 id_pc, fetch_fault, halted, fault_pc, e);
      end
    end
`endif
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e;
`ifdef FETCH_RANGE_CHECK_EN
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd396;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    id_ready = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({halted, id_valid, id_pc} !== {2'b11, 32'd400}) begin
      n_fail++;
      $display("FAIL halt_keeps_entry: got h=%b v=%b pc=%h want 1 1 190", halted, id_valid,
               id_pc);
    end
`else
    id_ready = 1'b0;
    step();
    n_cmp++;
    if (id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b want 1", id_valid);
    end
`endif
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({id_valid, fetch_fault, halted, imem_addr, id_pc, id_instr, fault_pc}
        !== {3'b000, 32'h0, 96'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b ff=%b h=%b addr=%h pc=%h ins=%h fpc=%h", id_valid,
               fetch_fault, halted, imem_addr, id_pc, id_instr, fault_pc);
    end
    id_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reboot_cycle: got v=%b addr=%h want v=0 addr=0", id_valid, imem_addr);
    end
    exp_q.push_back(32'h0);
    step();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, e, imem_f(e)}) begin
      n_fail++;
      $display("FAIL restart: got v=%b pc=%h want pc=%h", id_valid, id_pc, e);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_range();
    test_reset_midrun();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
